// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the Viterbi ACS scheduler and its path-metric bank.
package viterbi_pkg;

    localparam int NSTATES = 8;
    localparam int PM_W    = 8;
    localparam int BM_W    = 2;
    localparam int STATE_W = $clog2(NSTATES);

    typedef enum logic [1:0] {IDLE, RUN, NORM, OUT} state_t;

    // Predecessor j of state s is {s[STATE_W-2:0], j}.
    function automatic logic [STATE_W-1:0] pred0(input logic [STATE_W-1:0] s);
        return {s[STATE_W-2:0], 1'b0};
    endfunction

    function automatic logic [STATE_W-1:0] pred1(input logic [STATE_W-1:0] s);
        return {s[STATE_W-2:0], 1'b1};
    endfunction

    // Bit offset of the 2-bit branch metric for edge (pred j -> s) inside the BM vector.
    function automatic logic [STATE_W+1:0] bm_idx(input logic [STATE_W-1:0] s, input logic j);
        return {s, j, 1'b0};
    endfunction

endpackage

// File: rtl/acs_scheduler_pm_bank.sv
// Ping-pong path-metric bank: the current bank is read, the next bank is written,
// and a swap strobe flips them while optionally subtracting the normalisation offset.
module pm_bank
    import viterbi_pkg::*;
#(
    parameter int              NSTATES     = viterbi_pkg::NSTATES,
    parameter logic [PM_W-1:0] NORM_THRESH = 8'd128,
    localparam int             ST_W        = $clog2(NSTATES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ST_W-1:0] i_rd_addr0,
    input  logic [ST_W-1:0] i_rd_addr1,
    output logic            o_rd_vld0,
    output logic            o_rd_vld1,
    output logic [PM_W-1:0] o_rd_pm0,
    output logic [PM_W-1:0] o_rd_pm1,
    input  logic            i_wr_en,
    input  logic [ST_W-1:0] i_wr_addr,
    input  logic            i_wr_vld,
    input  logic [PM_W-1:0] i_wr_pm,
    input  logic            i_swap,
    input  logic            i_sub
);

    logic            r_sel;
    logic            w_nxt;
    logic [PM_W-1:0] w_pm_cur  [NSTATES];
    logic            w_vld_cur [NSTATES];

    assign w_nxt = ~r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= 1'b0;
        end else if (i_swap) begin
            r_sel <= ~r_sel;
        end
    end

    for (genvar g = 0; g < NSTATES; g++) begin : g_ent
        logic [PM_W-1:0] r_pm [2];
        logic [1:0]      r_vld;

        // Subtraction lands in the bank that becomes current on this same swap edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pm[0] <= '0;
                r_pm[1] <= '0;
                r_vld   <= {1'b0, (g == 0)};
            end else if (i_wr_en && (i_wr_addr == ST_W'(g))) begin
                r_pm[w_nxt]  <= i_wr_pm;
                r_vld[w_nxt] <= i_wr_vld;
            end else if (i_swap && i_sub && r_vld[w_nxt]) begin
                r_pm[w_nxt] <= r_pm[w_nxt] - NORM_THRESH;
            end
        end

        assign w_pm_cur[g]  = r_pm[r_sel];
        assign w_vld_cur[g] = r_vld[r_sel];
    end

    assign o_rd_pm0  = w_pm_cur[i_rd_addr0];
    assign o_rd_pm1  = w_pm_cur[i_rd_addr1];
    assign o_rd_vld0 = w_vld_cur[i_rd_addr0];
    assign o_rd_vld1 = w_vld_cur[i_rd_addr1];

endmodule

// File: rtl/acs_scheduler.sv
// Time-multiplexes one external ACS unit over all trellis states, one state per clock,
// producing a survivor word, best state and renormalisation flag per accepted symbol.
module acs_scheduler
    import viterbi_pkg::*;
#(
    parameter int              NSTATES     = viterbi_pkg::NSTATES,
    parameter logic [PM_W-1:0] NORM_THRESH = 8'd128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sym_valid_i,
    output logic                       sym_ready_o,
    input  logic [NSTATES*4-1:0]       sym_bm_i,
    output logic                       acs_p0_valid_o,
    output logic                       acs_p1_valid_o,
    output logic [BM_W-1:0]            acs_p0_bmc_o,
    output logic [BM_W-1:0]            acs_p1_bmc_o,
    output logic [PM_W-1:0]            acs_p0_pmc_o,
    output logic [PM_W-1:0]            acs_p1_pmc_o,
    input  logic                       acs_sel_i,
    input  logic                       acs_valid_i,
    input  logic [PM_W-1:0]            acs_cost_i,
    output logic                       surv_valid_o,
    input  logic                       surv_ready_i,
    output logic [NSTATES-1:0]         surv_bits_o,
    output logic [$clog2(NSTATES)-1:0] best_state_o,
    output logic                       norm_o
);

    localparam int ST_W = $clog2(NSTATES);

    state_t              r_state;
    logic [ST_W-1:0]     r_cnt;
    logic [NSTATES*4-1:0] r_bm;
    logic [NSTATES-1:0]  r_surv;
    logic [PM_W-1:0]     r_min;
    logic [ST_W-1:0]     r_min_state;
    logic                r_min_vld;
    logic [ST_W-1:0]     r_best;
    logic                r_norm;

    logic                w_run;
    logic                w_sub;
    logic [ST_W-1:0]     w_pred0;
    logic [ST_W-1:0]     w_pred1;
    logic [ST_W+1:0]     w_idx0;
    logic [ST_W+1:0]     w_idx1;
    logic                w_p0_vld;
    logic                w_p1_vld;
    logic [PM_W-1:0]     w_p0_pm;
    logic [PM_W-1:0]     w_p1_pm;

    assign w_run   = (r_state == RUN);
    assign w_sub   = r_min_vld && (r_min >= NORM_THRESH);
    assign w_pred0 = pred0(r_cnt);
    assign w_pred1 = pred1(r_cnt);
    assign w_idx0  = bm_idx(r_cnt, 1'b0);
    assign w_idx1  = bm_idx(r_cnt, 1'b1);

    pm_bank #(
        .NSTATES     (NSTATES),
        .NORM_THRESH (NORM_THRESH)
    ) u_pm_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_addr0 (w_pred0),
        .i_rd_addr1 (w_pred1),
        .o_rd_vld0  (w_p0_vld),
        .o_rd_vld1  (w_p1_vld),
        .o_rd_pm0   (w_p0_pm),
        .o_rd_pm1   (w_p1_pm),
        .i_wr_en    (w_run),
        .i_wr_addr  (r_cnt),
        .i_wr_vld   (acs_valid_i),
        .i_wr_pm    (acs_cost_i),
        .i_swap     (r_state == NORM),
        .i_sub      (w_sub)
    );

    // ACS operands are forced to zero whenever the scheduler is not sweeping states.
    assign acs_p0_valid_o = w_run & w_p0_vld;
    assign acs_p1_valid_o = w_run & w_p1_vld;
    assign acs_p0_bmc_o   = w_run ? r_bm[w_idx0 +: BM_W] : '0;
    assign acs_p1_bmc_o   = w_run ? r_bm[w_idx1 +: BM_W] : '0;
    assign acs_p0_pmc_o   = w_run ? w_p0_pm : '0;
    assign acs_p1_pmc_o   = w_run ? w_p1_pm : '0;

    assign sym_ready_o  = (r_state == IDLE);
    assign surv_valid_o = (r_state == OUT);
    assign surv_bits_o  = r_surv;
    assign best_state_o = r_best;
    assign norm_o       = r_norm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bm        <= '0;
            r_surv      <= '0;
            r_min       <= '0;
            r_min_state <= '0;
            r_min_vld   <= 1'b0;
            r_best      <= '0;
            r_norm      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sym_valid_i) begin
                        r_bm        <= sym_bm_i;
                        r_cnt       <= '0;
                        r_min       <= '0;
                        r_min_state <= '0;
                        r_min_vld   <= 1'b0;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    r_surv[r_cnt] <= acs_sel_i;
                    // Strict compare: on equal cost the lower-indexed state already held wins.
                    if (acs_valid_i && (!r_min_vld || (acs_cost_i < r_min))) begin
                        r_min       <= acs_cost_i;
                        r_min_state <= r_cnt;
                        r_min_vld   <= 1'b1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ST_W'(NSTATES - 1)) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_best  <= r_min_state;
                    r_norm  <= w_sub;
                    r_state <= OUT;
                end
                OUT: begin
                    if (surv_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acs_scheduler.sv
// Bench for acs_scheduler: combinational ACS unit on the acs_* ports, a trellis reference
// model feeding a scoreboard queue, and a monitor popping it on every survivor handshake.
module tb_acs_scheduler;

    localparam int NS  = 8;
    localparam int BMW = NS * 4;

    typedef struct packed {
        logic [NS-1:0] bits;
        logic [2:0]    best;
        logic          norm;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sym_valid_i = 1'b0;
    logic           sym_ready_o;
    logic [BMW-1:0] sym_bm_i = '0;
    logic           acs_p0_valid_o, acs_p1_valid_o;
    logic [1:0]     acs_p0_bmc_o, acs_p1_bmc_o;
    logic [7:0]     acs_p0_pmc_o, acs_p1_pmc_o;
    logic           acs_sel_i, acs_valid_i;
    logic [7:0]     acs_cost_i;
    logic           surv_valid_o;
    logic           surv_ready_i = 1'b0;
    logic [NS-1:0]  surv_bits_o;
    logic [2:0]     best_state_o;
    logic           norm_o;

    exp_t exp_q[$];
    exp_t exp_last;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_pm[NS];
    bit   m_vld[NS];
    bit   rdy_rand  = 1'b0;
    bit   rdy_fixed = 1'b1;
    logic [7:0] c0, c1;

    acs_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sym_valid_i    (sym_valid_i),
        .sym_ready_o    (sym_ready_o),
        .sym_bm_i       (sym_bm_i),
        .acs_p0_valid_o (acs_p0_valid_o),
        .acs_p1_valid_o (acs_p1_valid_o),
        .acs_p0_bmc_o   (acs_p0_bmc_o),
        .acs_p1_bmc_o   (acs_p1_bmc_o),
        .acs_p0_pmc_o   (acs_p0_pmc_o),
        .acs_p1_pmc_o   (acs_p1_pmc_o),
        .acs_sel_i      (acs_sel_i),
        .acs_valid_i    (acs_valid_i),
        .acs_cost_i     (acs_cost_i),
        .surv_valid_o   (surv_valid_o),
        .surv_ready_i   (surv_ready_i),
        .surv_bits_o    (surv_bits_o),
        .best_state_o   (best_state_o),
        .norm_o         (norm_o)
    );

    always #5 clk = ~clk;

    // The real add-compare-select unit: ties go to predecessor 0.
    always_comb begin
        c0          = acs_p0_pmc_o + {6'd0, acs_p0_bmc_o};
        c1          = acs_p1_pmc_o + {6'd0, acs_p1_bmc_o};
        acs_sel_i   = acs_p1_valid_o && (!acs_p0_valid_o || (c1 < c0));
        acs_valid_i = acs_p0_valid_o || acs_p1_valid_o;
        acs_cost_i  = !acs_valid_i ? 8'd0 : (acs_sel_i ? c1 : c0);
    end

    always @(posedge clk) begin
        #1;
        surv_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            m_pm[s]  = 0;
            m_vld[s] = (s == 0);
        end
    endfunction

    // Trellis step in plain integers: pred j of s is (2s mod NS)+j; ties keep pred 0.
    function automatic exp_t model_step(input logic [BMW-1:0] bm);
        exp_t e;
        int npm[NS];
        bit nv[NS];
        int mn, bst, p, c, bc, ch;
        logic [BMW-1:0] sh;
        e   = '0;
        mn  = -1;
        bst = 0;
        for (int s = 0; s < NS; s++) begin
            bc = -1;
            ch = 0;
            for (int j = 0; j < 2; j++) begin
                p  = ((2 * s) % NS) + j;
                sh = bm >> ((2 * s + j) * 2);
                c  = m_pm[p] + int'(sh[1:0]);
                if (m_vld[p] && (bc < 0 || c < bc)) begin
                    bc = c;
                    ch = j;
                end
            end
            nv[s]     = (bc >= 0);
            npm[s]    = nv[s] ? bc : 0;
            e.bits[s] = (ch == 1);
            if (nv[s] && (mn < 0 || npm[s] < mn)) begin
                mn  = npm[s];
                bst = s;
            end
        end
        e.best = 3'(bst);
        e.norm = (mn >= 128);
        for (int s = 0; s < NS; s++) begin
            m_vld[s] = nv[s];
            m_pm[s]  = (e.norm && nv[s]) ? npm[s] - 128 : npm[s];
        end
        return e;
    endfunction

    // Presents one symbol; optionally checks the ACS operands over the whole state sweep.
    task automatic send(input logic [BMW-1:0] bm, input bit chk_acs);
        int n;
        int pm_b[NS];
        bit v_b[NS];
        int p0;
        logic [BMW-1:0] sh;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!sym_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready_o) begin
            chk("sym_ready_timeout", {31'd0, sym_ready_o}, 32'd1);
            return;
        end
        for (int s = 0; s < NS; s++) begin
            pm_b[s] = m_pm[s];
            v_b[s]  = m_vld[s];
        end
        sym_bm_i    = bm;
        sym_valid_i = 1'b1;
        e = model_step(bm);
        exp_q.push_back(e);
        exp_last = e;
        @(posedge clk);
        #1;
        sym_valid_i = 1'b0;
        if (chk_acs) begin
            for (int k = 0; k < NS; k++) begin
                @(negedge clk);
                p0 = (2 * k) % NS;
                sh = bm >> (4 * k);
                chk("acs_p0_valid", {31'd0, acs_p0_valid_o}, {31'd0, v_b[p0]});
                chk("acs_p1_valid", {31'd0, acs_p1_valid_o}, {31'd0, v_b[p0 + 1]});
                chk("acs_p0_pmc", {24'd0, acs_p0_pmc_o}, pm_b[p0]);
                chk("acs_p1_pmc", {24'd0, acs_p1_pmc_o}, pm_b[p0 + 1]);
                chk("acs_p0_bmc", {30'd0, acs_p0_bmc_o}, {30'd0, sh[1:0]});
                chk("acs_p1_bmc", {30'd0, acs_p1_bmc_o}, {30'd0, sh[3:2]});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        sym_valid_i = 1'b0;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts edges from the one that opens the cycle presenting the symbol.
    task automatic check_latency(input string name);
        int n;
        n = 1;
        while (!surv_valid_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, NS + 2);
    endtask

    always @(negedge clk) begin
        if (rst_n && surv_valid_o && surv_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {31'd0, surv_valid_o}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("surv_bits", {24'd0, surv_bits_o}, {24'd0, e.bits});
                chk("best_state", {29'd0, best_state_o}, {29'd0, e.best});
                chk("norm", {31'd0, norm_o}, {31'd0, e.norm});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d words outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_surv_valid", {31'd0, surv_valid_o}, 32'd0);
        chk("rst_surv_bits", {24'd0, surv_bits_o}, 32'd0);
        chk("rst_best", {29'd0, best_state_o}, 32'd0);
        chk("rst_norm", {31'd0, norm_o}, 32'd0);
        chk("rst_acs_p0_valid", {31'd0, acs_p0_valid_o}, 32'd0);
        chk("rst_acs_p0_bmc", {30'd0, acs_p0_bmc_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sym_ready", {31'd0, sym_ready_o}, 32'd1);

        // Scenario 1: all-zero metrics from reset.
        send('0, 1'b0);
        check_latency("latency_s1");

        // Scenario 2: traceback stalls in OUT while stray symbols are offered.
        rdy_fixed = 1'b0;
        @(posedge clk);
        #2;
        send(32'h5A5A_5A5A, 1'b0);
        n = 0;
        while (!surv_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("s2_surv_valid", {31'd0, surv_valid_o}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("s2_hold_bits", {24'd0, surv_bits_o}, {24'd0, exp_last.bits});
            chk("s2_hold_best", {29'd0, best_state_o}, {29'd0, exp_last.best});
            chk("s2_hold_ready", {31'd0, sym_ready_o}, 32'd0);
            chk("s2_hold_valid", {31'd0, surv_valid_o}, 32'd1);
            sym_bm_i    = $urandom;
            sym_valid_i = 1'b1;
        end
        @(negedge clk);
        sym_valid_i = 1'b0;
        rdy_fixed   = 1'b1;
        send(32'h1234_5678, 1'b1);

        // Scenario 3: fill the trellis, then tie every comparison, then favour pred 1.
        do_reset();
        repeat (3) send('0, 1'b0);
        send('0, 1'b1);
        send(32'h3333_3333, 1'b1);

        // Scenario 4: maximum metrics until renormalisation, then inspect the PMs.
        do_reset();
        repeat (43) send('1, 1'b0);
        send('1, 1'b1);

        // Scenario 5: reset mid-sweep, then a clean repeat of scenario 1.
        do_reset();
        send('1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_surv_valid", {31'd0, surv_valid_o}, 32'd0);
        chk("s5_acs_p0_valid", {31'd0, acs_p0_valid_o}, 32'd0);
        chk("s5_acs_p1_bmc", {30'd0, acs_p1_bmc_o}, 32'd0);
        chk("s5_acs_p0_pmc", {24'd0, acs_p0_pmc_o}, 32'd0);
        chk("s5_surv_bits", {24'd0, surv_bits_o}, 32'd0);
        chk("s5_best", {29'd0, best_state_o}, 32'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s5_sym_ready", {31'd0, sym_ready_o}, 32'd1);
        send('0, 1'b0);
        check_latency("latency_s5");

        // Scenario 6: random metrics with random traceback back-pressure.
        do_reset();
        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send({$urandom}, (i % 50) == 7);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
        rdy_rand = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
